// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: RUN/STALL/FLUSH/MEMWAIT FSM with registered control decodes.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken,
  input  logic             load_use,
  input  logic             imem_ready,
`ifdef PIPE_CTRL_PERF_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             pc_en,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_STALL   = 2'b01,
    S_FLUSH   = 2'b10,
    S_MEMWAIT = 2'b11
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4 || CNT_W < 1) begin : g_param_check
    $error("pipe_ctrl: FLUSH_CYCLES must be 1..4 and CNT_W at least 1");
  end

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_pc_en;
  logic       r_if_id_stall;
  logic       r_if_id_flush;
  logic       r_id_ex_flush;
  state_t     w_nxt;
  logic [2:0] w_cnt_nxt;

  // A redirect wins in every state and (re)arms the flush counter.
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    if (branch_taken) begin
      w_nxt     = S_FLUSH;
      w_cnt_nxt = FLUSH_LOAD;
    end else begin
      case (r_state)
        S_RUN: begin
          if (load_use)         w_nxt = S_STALL;
          else if (!imem_ready) w_nxt = S_MEMWAIT;
        end
        S_STALL:   w_nxt = S_RUN;
        S_MEMWAIT: if (imem_ready) w_nxt = S_RUN;
        S_FLUSH: begin
          if (r_cnt == 3'd0) w_nxt = imem_ready ? S_RUN : S_MEMWAIT;
          else               w_cnt_nxt = r_cnt - 3'd1;
        end
        default: w_nxt = S_RUN;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land on the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_cnt         <= 3'd0;
      r_pc_en       <= 1'b0;
      r_if_id_stall <= 1'b0;
      r_if_id_flush <= 1'b0;
      r_id_ex_flush <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pc_en       <= (w_nxt == S_RUN) || (w_nxt == S_FLUSH);
      r_if_id_stall <= (w_nxt == S_STALL);
      r_if_id_flush <= (w_nxt == S_FLUSH) || (w_nxt == S_MEMWAIT);
      r_id_ex_flush <= (w_nxt == S_STALL) || (w_nxt == S_FLUSH);
    end
  end

  assign pc_en       = r_pc_en;
  assign if_id_stall = r_if_id_stall;
  assign if_id_flush = r_if_id_flush;
  assign id_ex_flush = r_id_ex_flush;
  assign state       = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_evt;
  logic             w_flush_evt;

  assign w_stall_evt = (r_state == S_STALL) || (r_state == S_MEMWAIT);
  assign w_flush_evt = (w_nxt == S_FLUSH) && ((r_state != S_FLUSH) || branch_taken);

  // Saturating counters; a synchronous clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal 1..4: number of cycles the FLUSH state is held per redirect.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk  input  1  pipeline clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port branch_taken  input  1  EX-stage redirect (taken branch or jump) this cycle.
REQ-006 SHALL have port load_use  input  1  ID instruction depends on a load currently in EX.
REQ-007 SHALL have port imem_ready  input  1  instruction memory returns valid fetch data this cycle.
REQ-008 SHALL have port pc_en  output  1  PC register update enable.
REQ-009 SHALL have port if_id_stall  output  1  hold the IF/ID buffer contents.
REQ-010 SHALL have port if_id_flush  output  1  load a zero bubble into the IF/ID buffer.
REQ-011 SHALL have port id_ex_flush  output  1  insert a bubble into the ID/EX stage.
REQ-012 SHALL have port state  output  2  current state: RUN=00, STALL=01, FLUSH=10, MEMWAIT=11.
REQ-013 SHALL have ports perf_clr (input, 1), stall_cnt (output, CNT_W) and flush_cnt (output, CNT_W), present only under PIPE_CTRL_PERF_EN.

Function
REQ-014 SHALL be a 4-state FSM; the event priority is branch_taken > load_use > !imem_ready.
REQ-015 In RUN, the FSM SHALL go to FLUSH on branch_taken, else to STALL on load_use, else to MEMWAIT on !imem_ready, else stay in RUN.
REQ-016 STALL SHALL last exactly one cycle, then go to FLUSH if branch_taken, else to RUN.
REQ-017 MEMWAIT SHALL hold while !imem_ready; branch_taken SHALL override and go to FLUSH; imem_ready alone SHALL return the FSM to RUN.
REQ-018 FLUSH SHALL load a 3-bit down-counter with FLUSH_CYCLES-1 on entry and leave when the counter is 0 and branch_taken is low: to MEMWAIT if !imem_ready, else to RUN.
REQ-019 branch_taken while in FLUSH SHALL reload the counter and keep the FSM in FLUSH.
REQ-020 All outputs SHALL be registered decodes of the next state, so they change on the same edge that samples the event (one-cycle latency from input to output).
REQ-021 The output decode SHALL be:
- RUN: pc_en=1, all others 0.
- STALL: if_id_stall=1, id_ex_flush=1, others 0.
- FLUSH: pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_stall=0.
- MEMWAIT: if_id_flush=1, others 0.
REQ-022 if_id_stall and if_id_flush SHALL never be asserted together.

Reset
REQ-023 rst SHALL asynchronously force state=RUN, the flush counter to 0 and pc_en, if_id_stall, if_id_flush, id_ex_flush to 0.
REQ-024 The first clk edge after rst deasserts SHALL load the decode of the next state, e.g. pc_en=1 when no event is present.
REQ-025 rst asserted mid-FLUSH or mid-MEMWAIT SHALL abandon the sequence with no residual count.

Configuration
REQ-026 With macro PIPE_CTRL_PERF_EN defined, stall_cnt SHALL increment each cycle state is STALL or MEMWAIT.
REQ-027 With PIPE_CTRL_PERF_EN defined, flush_cnt SHALL increment on each entry to FLUSH and on each reload within FLUSH.
REQ-028 Both counters SHALL saturate at all-ones, clear synchronously on perf_clr (clear wins over increment) and reset to 0.
REQ-029 Without PIPE_CTRL_PERF_EN, the perf ports and counter logic SHALL be absent and the FSM behaviour SHALL be identical.

Verification
REQ-030 Reset release with no events -> pc_en=1 and all flush/stall outputs 0 from the first edge; state=00.
REQ-031 load_use=1 for one cycle in RUN -> one cycle with if_id_stall=1, id_ex_flush=1, pc_en=0, then RUN.
REQ-032 FLUSH_CYCLES=3, branch_taken pulse -> exactly 3 cycles of if_id_flush=1, id_ex_flush=1, pc_en=1; a second branch_taken on FLUSH cycle 2 extends to 2+3 cycles.
REQ-033 branch_taken and load_use together -> FLUSH; imem_ready low for 4 cycles in RUN -> 4 MEMWAIT cycles with pc_en=0, if_id_flush=1.
REQ-034 branch_taken during MEMWAIT -> FLUSH on the next edge; rst pulse mid-FLUSH -> outputs 0 immediately and RUN after release.
REQ-035 PIPE_CTRL_PERF_EN with CNT_W=2 and 5 stall cycles -> stall_cnt=3 (saturated); perf_clr together with a stall cycle -> stall_cnt=0.
